// File: rtl/sha256_w_sched_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_w_sched_ctrl
//
// Sequencer for the SHA-256 message-schedule (W) memory. It takes one 512-bit
// block as 16 32-bit words on a valid/ready input stream. It then steps the W
// memory once per round, for rounds 0..63. Each schedule word returned by the
// memory is handed to the compression stage on a valid/ready output stream.
//
// Ports
//   CLK        in   1   clock, all state updates on posedge
//   RST        in   1   asynchronous active-high reset
//   START      in   1   begins a block when idle
//   WORD_IN    in  32   message word from the padder
//   WORD_VLD   in   1   WORD_IN valid
//   WORD_RDY   out  1   controller accepts WORD_IN this cycle
//   W_I        out  6   index to the W memory
//   W_DIN      out 32   data to the W memory (meaningful for W_I < 16)
//   W_STEP     out  1   one-cycle strobe, shifts the W memory window once
//   W_DOUT     in  32   W memory result for the current step
//   ROUND_W    out 32   schedule word W[ROUND_I]
//   ROUND_I    out  6   round number of ROUND_W
//   ROUND_VLD  out  1   ROUND_W / ROUND_I valid
//   ROUND_RDY  in   1   compression stage accepts this round
//   BUSY       out  1   block in progress
//   DONE       out  1   one-cycle pulse after round 63 is accepted
// ---------------------------------------------------------------------------
module sha256_w_sched_ctrl #(
  parameter int unsigned ROUNDS     = 64,
  parameter int unsigned LOAD_WORDS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] WORD_IN,
  input  logic        WORD_VLD,
  output logic        WORD_RDY,
  output logic [5:0]  W_I,
  output logic [31:0] W_DIN,
  output logic        W_STEP,
  input  logic [31:0] W_DOUT,
  output logic [31:0] ROUND_W,
  output logic [5:0]  ROUND_I,
  output logic        ROUND_VLD,
  input  logic        ROUND_RDY,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam logic [6:0] LAST_LOAD_C  = 7'(LOAD_WORDS - 1);
  localparam logic [6:0] LAST_ROUND_C = 7'(ROUNDS - 1);

  state_t      state_q;
  // 7 bits so that a finished count of 64 is distinct from 0
  logic [6:0]  cnt_q;
  logic [6:0]  cnt_d;
  logic        inflight_q;
  logic [5:0]  w_i_q;
  logic [31:0] w_din_q;
  logic        w_step_q;
  logic [31:0] round_w_q;
  logic [5:0]  round_i_q;
  logic        round_vld_q;
  logic        busy_q;
  logic        done_q;

  logic        free_s;
  logic        word_rdy_s;
  logic        issue_s;
  logic        accept_s;

  // Issue decision: a new step may go out only when the output slot will be
  // empty at the capture edge and no earlier step is still awaiting capture.
  always_comb begin
    free_s     = 1'b0;
    word_rdy_s = 1'b0;
    issue_s    = 1'b0;
    accept_s   = 1'b0;
    cnt_d      = cnt_q + 7'd1;
    free_s     = (~round_vld_q | ROUND_RDY) & ~inflight_q;
    accept_s   = round_vld_q & ROUND_RDY;
    case (state_q)
      ST_LOAD: begin
        word_rdy_s = free_s;
        issue_s    = free_s & WORD_VLD;
      end
      ST_EXPAND: begin
        issue_s = free_s;
      end
      default: begin
        word_rdy_s = 1'b0;
        issue_s    = 1'b0;
      end
    endcase
  end

  // Controller FSM with all registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 7'd0;
      inflight_q  <= 1'b0;
      w_i_q       <= 6'd0;
      w_din_q     <= 32'd0;
      w_step_q    <= 1'b0;
      round_w_q   <= 32'd0;
      round_i_q   <= 6'd0;
      round_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      w_step_q <= issue_s;
      done_q   <= 1'b0;

      if (issue_s) begin
        w_i_q      <= cnt_q[5:0];
        inflight_q <= 1'b1;
        cnt_q      <= cnt_d;
        if (state_q == ST_LOAD) begin
          w_din_q <= WORD_IN;
        end
      end

      // Capture the memory result of the step issued last cycle. Issue only
      // happens with the slot free, so a capture never overwrites a held word.
      if (inflight_q) begin
        round_w_q   <= W_DOUT;
        round_i_q   <= w_i_q;
        round_vld_q <= 1'b1;
        inflight_q  <= 1'b0;
      end else if (accept_s) begin
        round_vld_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          // done_q blocks a START that coincides with the DONE pulse
          if (START && !done_q) begin
            state_q <= ST_LOAD;
            cnt_q   <= 7'd0;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (issue_s && (cnt_q == LAST_LOAD_C)) begin
            state_q <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          if (issue_s && (cnt_q == LAST_ROUND_C)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (accept_s && (round_i_q == LAST_ROUND_C[5:0])) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign WORD_RDY  = word_rdy_s;
  assign W_I       = w_i_q;
  assign W_DIN     = w_din_q;
  assign W_STEP    = w_step_q;
  assign ROUND_W   = round_w_q;
  assign ROUND_I   = round_i_q;
  assign ROUND_VLD = round_vld_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule
